// File: rtl/mem_io_bridge_if.sv
// CPU-side, memory-side and IO-side signal bundle for mem_io_bridge.
// The bridge uses the slave modport; the CPU/memory/IO environment uses master.
interface mem_io_bridge_if #(
   parameter int DATA_W = 32,
   parameter int IO_W   = 16,
   parameter int IO_CH  = 4
);
   logic                  req_valid;
   logic                  req_we;
   logic [DATA_W-1:0]     addr_in;
   logic [DATA_W-1:0]     wdata;
   logic                  req_ready;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rdata;
   logic                  rsp_err;
   logic [DATA_W-1:0]     mem_addr;
   logic                  mem_we;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;
   logic [IO_CH-1:0]      io_cs;
   logic                  io_we;
   logic [IO_W-1:0]       io_wdata;
   logic [IO_CH*IO_W-1:0] io_rdata;

   modport slave (
      input  req_valid, req_we, addr_in, wdata, mem_rdata, io_rdata,
      output req_ready, rsp_valid, rdata, rsp_err,
             mem_addr, mem_we, mem_wdata, io_cs, io_we, io_wdata
   );

   modport master (
      output req_valid, req_we, addr_in, wdata, mem_rdata, io_rdata,
      input  req_ready, rsp_valid, rdata, rsp_err,
             mem_addr, mem_we, mem_wdata, io_cs, io_we, io_wdata
   );
endinterface

// File: rtl/mem_io_bridge.sv
// Steers CPU loads/stores to data memory or IO_CH memory-mapped IO channels.
// Optional macro IO_RD_SEXT_EN: sign-extend IO load data (default zero-extend).
module mem_io_bridge #(
   parameter int                DATA_W    = 32,
   parameter int                IO_W      = 16,
   parameter int                IO_CH     = 4,
   parameter logic [DATA_W-1:0] IO_BASE   = 32'hFFFF_FC00,
   parameter int                CH_STRIDE = 16,
   parameter int                MEM_LAT   = 1
) (
   input logic            clk,
   input logic            rst_n,
   mem_io_bridge_if.slave bus
);
   localparam int STRIDE_SH = $clog2(CH_STRIDE);
   localparam int CNT_W     = 2;
   localparam int CH_W      = 4;

   typedef enum logic [1:0] {IDLE = 2'd0, MEM_RD = 2'd1, RESP = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic              io_q, io_d;
   logic              err_q, err_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;
   logic              io_we_q, io_we_d;
   logic [IO_CH-1:0]  io_cs_q, io_cs_d;
   logic [IO_W-1:0]   io_wdata_q, io_wdata_d;

   logic              is_io, mapped, accept, capture;
   logic [DATA_W-1:0] io_off, ch_full;
   logic [CH_W-1:0]   ch_sel;
   logic [IO_W-1:0]   io_word;

   function automatic logic [DATA_W-1:0] io_extend(input logic [IO_W-1:0] v);
`ifdef IO_RD_SEXT_EN
      return {{(DATA_W-IO_W){v[IO_W-1]}}, v};
`else
      return {{(DATA_W-IO_W){1'b0}}, v};
`endif
   endfunction

   always_comb begin
      is_io   = bus.addr_in >= IO_BASE;
      io_off  = bus.addr_in - IO_BASE;
      ch_full = io_off >> STRIDE_SH;
      mapped  = ch_full < DATA_W'(IO_CH);
      ch_sel  = ch_full[CH_W-1:0];
      accept  = bus.req_valid && (state_q == IDLE);
      capture = (state_q == MEM_RD) && (cnt_q == '0) && !we_q;
   end

   always_comb begin
      io_word = '0;
      for (int c = 0; c < IO_CH; c++)
         if (ch_q == CH_W'(c)) io_word = bus.io_rdata[c*IO_W +: IO_W];
   end

   // Every mapped access spends at least one cycle in MEM_RD carrying its strobe;
   // only unmapped IO skips straight to the response.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = (is_io && !mapped) ? RESP : MEM_RD;
         MEM_RD:  if (cnt_q == '0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      we_d        = we_q;
      io_d        = io_q;
      err_d       = err_q;
      ch_d        = ch_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      io_wdata_d  = io_wdata_q;
      mem_we_d    = 1'b0;
      io_we_d     = 1'b0;
      io_cs_d     = '0;
      if (accept) begin
         we_d  = bus.req_we;
         io_d  = is_io;
         ch_d  = ch_sel;
         err_d = is_io && !mapped;
         cnt_d = (!is_io && !bus.req_we) ? CNT_W'(MEM_LAT-1) : '0;
         if (!is_io) begin
            mem_addr_d = bus.addr_in;
            if (bus.req_we) begin
               mem_we_d    = 1'b1;
               mem_wdata_d = bus.wdata;
            end
         end else if (mapped) begin
            io_cs_d = IO_CH'(1) << ch_sel;
            if (bus.req_we) begin
               io_we_d    = 1'b1;
               io_wdata_d = bus.wdata[IO_W-1:0];
            end
         end else if (!bus.req_we) begin
            rdata_d = '0;
         end
      end else if ((state_q == MEM_RD) && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
      if (capture) rdata_d = io_q ? io_extend(io_word) : bus.mem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         io_q        <= 1'b0;
         err_q       <= 1'b0;
         ch_q        <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         io_we_q     <= 1'b0;
         io_cs_q     <= '0;
         io_wdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         io_q        <= io_d;
         err_q       <= err_d;
         ch_q        <= ch_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         io_we_q     <= io_we_d;
         io_cs_q     <= io_cs_d;
         io_wdata_q  <= io_wdata_d;
      end
   end

   always_comb begin
      bus.req_ready = (state_q == IDLE);
      bus.rsp_valid = (state_q == RESP);
      bus.rsp_err   = (state_q == RESP) && err_q;
      bus.rdata     = rdata_q;
      bus.mem_addr  = mem_addr_q;
      bus.mem_we    = mem_we_q;
      bus.mem_wdata = mem_wdata_q;
      bus.io_cs     = io_cs_q;
      bus.io_we     = io_we_q;
      bus.io_wdata  = io_wdata_q;
   end
endmodule
